// File: rtl/inbuf_rd_ctrl_pkg.sv
// Shared accelerator definitions for the input-buffer read controller.
// Holds the controller state enum and the default bus/counter widths.
package inbuf_rd_ctrl_pkg;

  localparam int INBUF_DATA_W_DEF = 256;
  localparam int CNT_W_DEF        = 16;
  localparam int SKID_DEPTH_DEF   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/inbuf_skid_buf.sv
// Two-entry in-order skid buffer; head entry is always presented on head_dat_o.
// Latency 1 cycle push-to-head; simultaneous push/pop keeps occupancy, push when full without pop is dropped.
module inbuf_skid_buf #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_dat_o
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              do_push, do_pop;

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_dat_i;
        else               ent1_d = push_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b11: begin
        // Head leaves while the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          ent0_d = push_dat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign full_o     = (cnt_q == 2'd2);
  assign empty_o    = (cnt_q == 2'd0);
  assign head_dat_o = ent0_q;

endmodule

// File: rtl/inbuf_rd_ctrl.sv
// Input-buffer read controller: fetches num_words FIFO words into a 2-entry skid buffer feeding the multiplier.
// Latency: FIFO data valid in cycle n shows on mult_val in n+1; reads throttle on skid credits (mult_rdy backpressure).
// Optional statistics outputs (stat_words, stat_stall) exist only when INBUF_RD_CTRL_STATS_EN is defined.
module inbuf_rd_ctrl
  import inbuf_rd_ctrl_pkg::*;
#(
  parameter int INBUF_DATA_W = INBUF_DATA_W_DEF,
  parameter int SKID_DEPTH   = SKID_DEPTH_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_words,
  input  logic                    inbuf_fifo_cntl_empty,
  input  logic                    inbuf_dout_reg_val,
  input  logic [INBUF_DATA_W-1:0] inbuf_rd_data,
  output logic                    cntl_inbuf_fifo_rd_rq,
  output logic                    cntl_inbuf_fifo_mem_en,
  output logic [INBUF_DATA_W-1:0] mult_data,
  output logic                    mult_val,
  input  logic                    mult_rdy,
  output logic                    mult_last,
  output logic                    busy,
  output logic                    done
`ifdef INBUF_RD_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_words,
  output logic [31:0]             stat_stall
`endif
);

  localparam logic [2:0] SKID_LIM = 3'(SKID_DEPTH);

  rd_state_e        state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] deliv_q, deliv_d;
  logic             inflight_q;
  logic             done_q;

  logic             skid_push, skid_pop, skid_full, skid_empty;
  logic [1:0]       occ;
  logic [2:0]       used;
  logic             rd_rq;

  // A pop in this cycle frees its slot before the new read's data can land,
  // which is what allows one word per cycle with mult_rdy held high.
  always_comb begin
    occ       = skid_full ? 2'd2 : (skid_empty ? 2'd0 : 2'd1);
    skid_pop  = !skid_empty && mult_rdy;
    skid_push = inbuf_dout_reg_val && inflight_q;
    used      = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, skid_pop};
    rd_rq     = (state_q == FETCH) && !inbuf_fifo_cntl_empty &&
                (rem_q != '0) && (used < SKID_LIM);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    total_d = total_q;
    deliv_d = deliv_q;
    if (skid_pop) deliv_d = deliv_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          total_d = num_words;
          rem_d   = num_words;
          deliv_d = '0;
          state_d = (num_words == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (rd_rq) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight_q && skid_empty) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      total_q    <= '0;
      deliv_q    <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      total_q    <= total_d;
      deliv_q    <= deliv_d;
      inflight_q <= rd_rq;
      done_q     <= (state_q == DONE);
    end
  end

  inbuf_skid_buf #(
    .DATA_W(INBUF_DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (skid_push),
    .push_dat_i(inbuf_rd_data),
    .pop_i     (skid_pop),
    .full_o    (skid_full),
    .empty_o   (skid_empty),
    .head_dat_o(mult_data)
  );

  assign cntl_inbuf_fifo_rd_rq  = rd_rq;
  assign cntl_inbuf_fifo_mem_en = rd_rq;
  assign mult_val               = !skid_empty;
  assign mult_last              = !skid_empty && (deliv_q == total_q - CNT_W'(1));
  assign busy                   = (state_q != IDLE);
  assign done                   = done_q;

`ifdef INBUF_RD_CTRL_STATS_EN
  logic        start_ok;
  logic [31:0] stat_words_q, stat_stall_q;

  assign start_ok = start && (state_q == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else if (start_ok) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (skid_pop && (stat_words_q != '1)) stat_words_q <= stat_words_q + 32'd1;
      if (!skid_empty && !mult_rdy && (stat_stall_q != '1)) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_inbuf_rd_ctrl.sv
// Randomized self-checking bench for inbuf_rd_ctrl against a word-count/queue model.
module tb_inbuf_rd_ctrl;

  localparam int W  = 256;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          inbuf_fifo_cntl_empty = 1'b1;
  logic          inbuf_dout_reg_val = 1'b0;
  logic [W-1:0]  inbuf_rd_data = '0;
  logic          cntl_inbuf_fifo_rd_rq, cntl_inbuf_fifo_mem_en;
  logic [W-1:0]  mult_data;
  logic          mult_val, mult_last, busy, done;
  logic          mult_rdy = 1'b0;
`ifdef INBUF_RD_CTRL_STATS_EN
  logic [31:0]   stat_words, stat_stall;
`endif

  always #5 clk = ~clk;

  inbuf_rd_ctrl dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .start                 (start),
    .num_words             (num_words),
    .inbuf_fifo_cntl_empty (inbuf_fifo_cntl_empty),
    .inbuf_dout_reg_val    (inbuf_dout_reg_val),
    .inbuf_rd_data         (inbuf_rd_data),
    .cntl_inbuf_fifo_rd_rq (cntl_inbuf_fifo_rd_rq),
    .cntl_inbuf_fifo_mem_en(cntl_inbuf_fifo_mem_en),
    .mult_data             (mult_data),
    .mult_val              (mult_val),
    .mult_rdy              (mult_rdy),
    .mult_last             (mult_last),
    .busy                  (busy),
    .done                  (done)
`ifdef INBUF_RD_CTRL_STATS_EN
    ,
    .stat_words            (stat_words),
    .stat_stall            (stat_stall)
`endif
  );

  int errs = 0, checks = 0, cyc = 0;

  // Model: a job is just counts of words requested and delivered.
  logic [W-1:0] words[$];
  bit act = 0, fetch_act = 0, last_rd = 0, prev_dut_rd = 0, done_seen = 0;
  int jn = 0, issued = 0, popped = 0, done_cyc = -1, fifo_idx = 0, start_cyc = 0;

  // Observations of the DUT for the directed scenarios.
  bit dut_rd_s = 0;
  int first_pop = -1, last_pop = -1, dut_out = 0, max_out = 0;
  int rd_while_emp = 0, rd_in_stall = 0, dut_pops = 0, dut_rds = 0;

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, a, e);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] w;
    for (int k = 0; k < W/32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic model_clear();
    act = 0; fetch_act = 0; last_rd = 0; prev_dut_rd = 0;
    issued = 0; popped = 0; jn = 0; done_cyc = -1; fifo_idx = 0;
  endtask

  task automatic step(input bit st, input int nw, input bit rdy, input bit emp);
    int buffered;
    bit e_val, e_pop, e_rd, e_done, e_busy;
    @(posedge clk);
    cyc++;
    #1;
    start = st;
    num_words = CW'(nw);
    mult_rdy = rdy;
    inbuf_fifo_cntl_empty = emp;
    inbuf_dout_reg_val = prev_dut_rd;
    if (prev_dut_rd && fifo_idx < words.size()) begin
      inbuf_rd_data = words[fifo_idx];
      fifo_idx++;
    end else begin
      inbuf_rd_data = rand_word();
    end
    @(negedge clk);
    buffered = issued - int'(last_rd) - popped;
    e_val  = (buffered > 0);
    e_pop  = e_val && rdy;
    e_rd   = fetch_act && !emp && (issued < jn) && ((issued - popped - int'(e_pop)) < 2);
    e_done = act && (cyc == done_cyc);
    e_busy = act && !e_done;
    chk("rd_rq", W'(cntl_inbuf_fifo_rd_rq), W'(e_rd));
    chk("mem_en", W'(cntl_inbuf_fifo_mem_en), W'(e_rd));
    chk("mult_val", W'(mult_val), W'(e_val));
    chk("busy", W'(busy), W'(e_busy));
    chk("done", W'(done), W'(e_done));
    if (e_val && popped < words.size()) begin
      chk("mult_data", mult_data, words[popped]);
      chk("mult_last", W'(mult_last), W'(popped == jn - 1));
    end else begin
      chk("mult_last_nv", W'(mult_last), W'(0));
    end
    dut_rd_s = cntl_inbuf_fifo_rd_rq;
    prev_dut_rd = cntl_inbuf_fifo_rd_rq;
    if (cntl_inbuf_fifo_rd_rq) begin dut_rds++; dut_out++; end
    if (cntl_inbuf_fifo_rd_rq && emp) rd_while_emp++;
    if (mult_val && mult_rdy) begin dut_pops++; dut_out--; end
    if (dut_out > max_out) max_out = dut_out;
    if (e_pop) begin
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end
    if (e_rd) issued++;
    last_rd = e_rd;
    if (e_pop) begin
      popped++;
      if (popped == jn) done_cyc = cyc + 3;
    end
    if (fetch_act && issued >= jn) fetch_act = 0;
    if (e_done) begin act = 0; done_seen = 1; end
    if (st && !act) begin
      act = 1; jn = nw; issued = 0; popped = 0; last_rd = 0; fifo_idx = 0;
      fetch_act = (nw > 0);
      done_cyc = (nw == 0) ? cyc + 2 : -1;
    end
  endtask

  task automatic run_job(input int n, input int rdy_pct, input int emp_pct,
                         input int st_lo, input int st_hi, input int em_lo, input int em_hi,
                         input bit spur);
    bit rdy, emp, sp;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(rand_word());
    done_seen = 0; first_pop = -1; last_pop = -1; dut_out = 0; max_out = 0;
    rd_while_emp = 0; rd_in_stall = 0; dut_pops = 0; dut_rds = 0;
    step(1'b1, n, 1'b1, 1'b0);
    start_cyc = cyc;
    for (int r = 1; r < 600 && !done_seen; r++) begin
      rdy = (r >= st_lo && r <= st_hi) ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
      emp = (r >= em_lo && r <= em_hi) ? 1'b1 : ($urandom_range(0, 99) < emp_pct);
      sp  = spur && fetch_act && ($urandom_range(0, 9) == 0);
      step(sp, int'($urandom_range(0, 20)), rdy, emp);
      if (r >= st_lo && r <= st_hi && dut_rd_s) rd_in_stall++;
    end
    if (!done_seen) begin
      checks++; errs++;
      $display("FAIL job_timeout n=%0d got=no_done expected=done", n);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_rq"}, W'(cntl_inbuf_fifo_rd_rq), W'(0));
    chk({tag, "_mem_en"}, W'(cntl_inbuf_fifo_mem_en), W'(0));
    chk({tag, "_mult_val"}, W'(mult_val), W'(0));
    chk({tag, "_mult_last"}, W'(mult_last), W'(0));
    chk({tag, "_mult_data"}, mult_data, W'(0));
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
  endtask

  initial begin
    // Power-on reset.
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    model_clear();

    // Four words, full rate: beats back to back, done 9 cycles after start.
    run_job(4, 100, 0, -1, -1, -1, -1, 1'b0);
    chk("j4_beats_span", W'(last_pop - first_pop), W'(3));
    chk("j4_done_lat", W'(done_cyc - start_cyc), W'(9));
    chk("j4_pops", W'(dut_pops), W'(4));

    // Eight words, consumer stalls 5 cycles mid-job.
    run_job(8, 100, 0, 4, 8, -1, -1, 1'b0);
    chk("j8stall_rd_in_stall", W'(rd_in_stall), W'(0));
    chk("j8stall_max_out_le2", W'(max_out <= 2), W'(1));
    chk("j8stall_pops", W'(dut_pops), W'(8));

    // Eight words, FIFO empty for 3 cycles during fetch.
    run_job(8, 100, 0, -1, -1, 3, 5, 1'b0);
    chk("j8emp_rd_while_empty", W'(rd_while_emp), W'(0));
    chk("j8emp_pops", W'(dut_pops), W'(8));

    // Zero-word job: no reads, done two cycles after start.
    run_job(0, 100, 0, -1, -1, -1, -1, 1'b0);
    chk("j0_rds", W'(dut_rds), W'(0));
    chk("j0_done_lat", W'(done_cyc - start_cyc), W'(2));

`ifdef INBUF_RD_CTRL_STATS_EN
    run_job(4, 100, 0, 4, 6, -1, -1, 1'b0);
    chk("stat_words", W'(stat_words), W'(4));
    chk("stat_stall", W'(stat_stall), W'(3));
`endif

    // Randomized jobs with backpressure, FIFO gaps and ignored start pulses.
    for (int j = 0; j < 12; j++) begin
      run_job(int'($urandom_range(1, 12)), int'($urandom_range(30, 100)),
              int'($urandom_range(0, 50)), -1, -1, -1, -1, 1'b1);
      chk("rand_pops", W'(dut_pops), W'(jn));
    end

    // Reset with one read in flight and one word buffered.
    words.delete();
    for (int i = 0; i < 8; i++) words.push_back(rand_word());
    step(1'b1, 8, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    @(posedge clk); cyc++; #1;
    inbuf_dout_reg_val = prev_dut_rd;
    inbuf_rd_data = words[1];
    #1 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(posedge clk); cyc++; #1;
    rst_n = 1'b1;
    inbuf_dout_reg_val = 1'b1;
    inbuf_rd_data = rand_word();
    @(negedge clk);
    chk("late_val_mult_val", W'(mult_val), W'(0));
    chk("late_val_busy", W'(busy), W'(0));
    @(posedge clk); cyc++; #1;
    inbuf_dout_reg_val = 1'b0;
    @(negedge clk);
    chk("after_late_mult_val", W'(mult_val), W'(0));
    chk("after_late_rd_rq", W'(cntl_inbuf_fifo_rd_rq), W'(0));
    model_clear();

    // Normal operation resumes after the mid-job reset.
    run_job(3, 100, 0, -1, -1, -1, -1, 1'b0);
    chk("post_rst_pops", W'(dut_pops), W'(3));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/inbuf_rd_ctrl.md
INBUF_RD_CTRL -- requirements
Module: inbuf_rd_ctrl

Interface
REQ-001 SHALL have parameter INBUF_DATA_W, default 256, meaning FIFO read word width in bits.
REQ-002 SHALL have parameter SKID_DEPTH, default 2, meaning output buffer entries; fixed at 2.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the job word count.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle job start pulse; honoured only in IDLE.
REQ-007 SHALL have port num_words  input  CNT_W  words in the job, sampled on start; 0 means no reads.
REQ-008 SHALL have port inbuf_fifo_cntl_empty  input  1  input buffer FIFO empty.
REQ-009 SHALL have port inbuf_dout_reg_val  input  1  FIFO read data valid, exactly 1 cycle after rd_rq.
REQ-010 SHALL have port inbuf_rd_data  input  INBUF_DATA_W  FIFO read data.
REQ-011 SHALL have port cntl_inbuf_fifo_rd_rq  output  1  FIFO read request.
REQ-012 SHALL have port cntl_inbuf_fifo_mem_en  output  1  FIFO memory enable.
REQ-013 SHALL have port mult_data  output  INBUF_DATA_W  data to the multiplier array.
REQ-014 SHALL have port mult_val  output  1  mult_data valid.
REQ-015 SHALL have port mult_rdy  input  1  multiplier array ready.
REQ-016 SHALL have port mult_last  output  1  marks the final word of the job, qualified by mult_val.
REQ-017 SHALL have port busy  output  1  high in any state but IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse at job completion.

Function
REQ-019 SHALL implement FSM states IDLE, FETCH, DRAIN, DONE.
REQ-020 SHALL transition IDLE->FETCH on start with num_words>0, and IDLE->DONE on start with num_words==0.
REQ-021 SHALL transition FETCH->DRAIN in the cycle after the last read request issues; DRAIN->DONE when no read is in flight and the skid buffer is empty; DONE->IDLE unconditionally.
REQ-022 SHALL assert cntl_inbuf_fifo_rd_rq only in FETCH, with !inbuf_fifo_cntl_empty, words remaining >0, and (skid occupancy + in-flight reads) < 2.
REQ-023 SHALL drive cntl_inbuf_fifo_mem_en equal to cntl_inbuf_fifo_rd_rq.
REQ-024 SHALL write inbuf_rd_data into the skid buffer in any cycle where inbuf_dout_reg_val is high; the credit rule guarantees no overflow.
REQ-025 SHALL present the skid buffer head as mult_data with mult_val; an entry pops on mult_val && mult_rdy.
REQ-026 SHALL support a simultaneous push and pop in the same cycle with occupancy unchanged, preserving order.
REQ-027 SHALL give one-cycle bypass-free latency: data valid in cycle n appears on mult_val in cycle n+1.
REQ-028 SHALL assert mult_last on the entry whose delivery index equals num_words-1.
REQ-029 SHALL sustain one word per cycle when the FIFO is non-empty and mult_rdy is held high.
REQ-030 SHALL hold mult_data and mult_val stable while mult_val && !mult_rdy.
REQ-031 SHALL ignore start outside IDLE.

Reset
REQ-032 SHALL on rst_n low asynchronously force: state IDLE, counters 0, skid buffer empty; outputs rd_rq 0, mem_en 0, mult_val 0, mult_last 0, mult_data 0, busy 0, done 0.
REQ-033 SHALL on reset mid-job discard in-flight and buffered words, and ignore read data returning after reset release.

Configuration
REQ-034 SHALL with macro INBUF_RD_CTRL_STATS_EN defined add outputs stat_words (32 b, words delivered) and stat_stall (32 b, cycles with mult_val && !mult_rdy); both clear on reset and on start, and saturate at all-ones.
REQ-035 SHALL without INBUF_RD_CTRL_STATS_EN omit those ports and counters entirely.

Structure
REQ-036 SHALL take the FSM state enum and the INBUF_DATA_W and CNT_W defaults from the shared accelerator package.
REQ-037 SHALL implement the 2-entry skid buffer as sub-module inbuf_skid_buf (push, pop, full, empty, head data).

Verification
REQ-038 SHALL cover num_words=4, FIFO non-empty, mult_rdy=1 -> 4 consecutive mult_val beats, mult_last on the 4th, done 1 cycle after DRAIN exits.
REQ-039 SHALL cover num_words=8 with mult_rdy low for 5 cycles mid-job -> at most 2 reads outstanding or buffered, no data loss or reorder, rd_rq low during the stall.
REQ-040 SHALL cover FIFO empty for 3 cycles during FETCH -> no rd_rq while empty, and the job completes with all 8 words.
REQ-041 SHALL cover start with num_words=0 -> no rd_rq, done pulses 2 cycles after start.
REQ-042 SHALL cover rst_n asserted with 1 read in flight and 1 word buffered -> all outputs 0 immediately, IDLE after release, and the late rd_data_val is ignored.
REQ-043 SHALL cover, with INBUF_RD_CTRL_STATS_EN, a 4-word job with a 3-cycle stall -> stat_words=4 and stat_stall=3.
